// File: rtl/sram_burst_ctrl_if.sv
// Command, write-data, read-data and external SRAM pins of the burst controller.
// The slave modport is the controller's view; master is the user/board side.
interface sram_burst_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int BUS_W  = 16,
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;

  logic [ADDR_W-1:0] sram_addr;
  logic [BUS_W-1:0]  sram_dq_o;
  logic              sram_dq_oe;
  logic [BUS_W-1:0]  sram_dq_i;
  logic              sram_ce_n;
  logic              sram_lb_n;
  logic              sram_ub_n;
  logic              ram_clk;
  logic              ram_adv;
  logic              sram_we_n;
  logic              sram_oe_n;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, sram_dq_i,
    output cmd_ready, wr_ready, rd_data, rd_valid, done,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_lb_n, sram_ub_n,
    output ram_clk, ram_adv, sram_we_n, sram_oe_n
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, sram_dq_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_lb_n, sram_ub_n,
    input  ram_clk, ram_adv, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Asynchronous SRAM burst controller: moves WORD_W-bit words over a BUS_W-bit bus,
// most-significant slice first, with a programmable strobe width and address wrap.
module sram_burst_ctrl #(
  parameter int ADDR_W      = 19,
  parameter int BUS_W       = 16,
  parameter int WORD_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int LEN_W       = 16
) (
  input logic             clk,
  input logic             reset,
  sram_burst_ctrl_if.slave bus
);

  localparam int SLICES = WORD_W / BUS_W;
  localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int WC_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [SL_W-1:0] TOP_SLICE = SL_W'(SLICES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              write_q, write_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SL_W-1:0]   slice_q, slice_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] word_cap;
  logic [WORD_W-1:0] word_shift;

  // word_q doubles as the write shift register (its top slice is the bus) and the read assembler.
  generate
    if (SLICES > 1) begin : g_multi
      assign word_cap   = {word_q[WORD_W-BUS_W-1:0], bus.sram_dq_i};
      assign word_shift = {word_q[WORD_W-BUS_W-1:0], {BUS_W{1'b0}}};
    end else begin : g_single
      assign word_cap   = bus.sram_dq_i;
      assign word_shift = word_q;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    write_d     = write_q;
    len_d       = len_q;
    slice_d     = slice_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    word_d      = word_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          write_d     = bus.cmd_write;
          addr_d      = bus.cmd_addr;
          len_d       = bus.cmd_len;
          slice_d     = TOP_SLICE;
          if (bus.cmd_write) begin
            state_d = WAIT_DATA;
          end else begin
            state_d = SETUP;
            oe_n_d  = 1'b0;
          end
        end
      end

      WAIT_DATA: begin
        if (bus.wr_valid) begin
          word_d  = bus.wr_data;
          dq_oe_d = 1'b1;
          state_d = SETUP;
        end
      end

      SETUP: begin
        state_d = STROBE;
        wait_d  = WAIT_LAST;
        we_n_d  = ~write_q;
      end

      STROBE: begin
        if (wait_q == '0) begin
          state_d = HOLD;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (!write_q) begin
            word_d = word_cap;
            if (slice_q == '0) begin
              rd_data_d  = word_cap;
              rd_valid_d = 1'b1;
            end
          end
        end else begin
          wait_d = wait_q - WC_W'(1);
        end
      end

      HOLD: begin
        addr_d = addr_q + ADDR_W'(1);
        if (slice_q != '0) begin
          slice_d = slice_q - SL_W'(1);
          state_d = SETUP;
          if (write_q) word_d = word_shift;
          else         oe_n_d = 1'b0;
        end else if (len_q != '0) begin
          len_d   = len_q - LEN_W'(1);
          slice_d = TOP_SLICE;
          if (write_q) begin
            state_d = WAIT_DATA;
            dq_oe_d = 1'b0;
          end else begin
            state_d = SETUP;
            oe_n_d  = 1'b0;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          dq_oe_d = 1'b0;
        end
      end

      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      write_q     <= 1'b0;
      len_q       <= '0;
      slice_q     <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      len_q       <= len_d;
      slice_q     <= slice_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

  // wr_ready is combinational so the producer sees it in the very cycle its word is taken.
  assign bus.wr_ready   = (state_q == WAIT_DATA) && bus.wr_valid;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.done       = done_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = word_q[WORD_W-1 -: BUS_W];
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_ce_n  = 1'b0;
  assign bus.sram_lb_n  = 1'b0;
  assign bus.sram_ub_n  = 1'b0;
  assign bus.ram_clk    = 1'b0;
  assign bus.ram_adv    = 1'b0;

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised asynchronous SRAM controller that packs WORD_W-bit words onto a BUS_W-bit external SRAM bus, most-significant slice first, and moves multi-word bursts in either direction under a command handshake. It sits between the vision pipeline's frame and buffer logic and the board's asynchronous SRAM. It adds:

- programmable strobe width;
- burst length with write-data flow control;
- explicit tristate control;
- address wrap;
- a completion pulse.

## Interface

Parameters:

- ADDR_W, 19, SRAM halfword address width
- BUS_W, 16, external data bus width
- WORD_W, 32, user word width; must be an integer multiple of BUS_W; SLICES = WORD_W/BUS_W
- WAIT_CYCLES, 2, cycles the WE_N/OE_N strobe is held low per slice (>=1)
- LEN_W, 16, burst length field width

Ports:

- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  base halfword address
- cmd_len  in  LEN_W  burst length minus one, in words
- wr_data  in  WORD_W  write word
- wr_valid  in  1  write word available
- wr_ready  out  1  one-cycle pulse when wr_data is consumed
- rd_data  out  WORD_W  assembled read word
- rd_valid  out  1  one-cycle pulse per read word; no backpressure
- done  out  1  one-cycle pulse at burst completion
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  BUS_W  data to SRAM
- sram_dq_oe  out  1  drive enable for top-level tristate
- sram_dq_i  in  BUS_W  data from SRAM
- sram_ce_n, sram_lb_n, sram_ub_n, ram_clk, ram_adv  out  1  constant 0 (asynchronous mode)
- sram_we_n, sram_oe_n  out  1  active-low strobes

## Operation

- States: IDLE, WAIT_DATA, SETUP, STROBE, HOLD, DONE.
- IDLE: cmd_valid & cmd_ready latches addr, len and direction.
  - Write goes to WAIT_DATA.
  - Read goes to SETUP.
- WAIT_DATA (write only): entered at the start of every word.
  - Strobes are high and sram_dq_oe is 0.
  - When wr_valid=1: latch wr_data, pulse wr_ready for that cycle, go to SETUP.
- Per slice (index s, upper slice first):
  - SETUP, 1 cycle: sram_addr valid. Write: dq_oe=1 with the slice data driven. Read: oe_n=0.
  - STROBE, WAIT_CYCLES cycles: write holds we_n=0; read holds oe_n=0. On a read, sram_dq_i is captured on the last STROBE cycle.
  - HOLD, 1 cycle: we_n=1 with data still driven (write), or oe_n=1 (read). At the end of HOLD, sram_addr increments.
- Address arithmetic: modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 silently.
- After the last slice's HOLD:
  - A read pulses rd_valid with the assembled word.
  - If words remain, go to SETUP (read) or WAIT_DATA (write). Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- cmd_valid outside IDLE is ignored. The command is not queued.
- Write and read never overlap: dq_oe=0 whenever oe_n=0.

## Timing

- Reset values, applied on the edge where reset=1:
  - state=IDLE, cmd_ready=1;
  - wr_ready=0, rd_valid=0, done=0;
  - we_n=1, oe_n=1, dq_oe=0;
  - sram_addr=0, rd_data=0, sram_dq_o=0.
- Reset mid-burst aborts immediately, with no done and no further rd_valid. SRAM contents already written stay written.
- Slice cost: 2+WAIT_CYCLES cycles. Word cost: SLICES*(2+WAIT_CYCLES) cycles, plus WAIT_DATA stall cycles on writes (minimum one cycle per word).
- Read latency: command accepted at edge 0 gives rd_valid high in cycle SLICES*(2+WAIT_CYCLES) (the HOLD of the last slice).
- done asserts in the cycle after the final HOLD.
- cmd_ready returns to 1 in the cycle after done.
- Addresses and write data are stable for at least one full cycle before a strobe falls and one cycle after it rises.
- cmd_len=0 means one word. cmd_len=2^LEN_W-1 means 2^LEN_W words.

## Test plan

1. Defaults, write 1 word 0xDEADBEEF at 0x00010, wr_valid high. Required: 0xDEAD at 0x10 and 0xBEEF at 0x11; we_n low exactly 2 cycles per slice; one wr_ready pulse; done 10 cycles after acceptance.
2. Read burst cmd_len=3 at 0x00100, with an SRAM model preloaded 0x0001..0x0008. Required: rd_data = 0x00010002, 0x00030004, 0x00050006, 0x00070008, rd_valid spaced 8 cycles apart; dq_oe never 1 while oe_n=0.
3. Write burst of 3 words with wr_valid low for 5 cycles before word 2. Required: controller holds in WAIT_DATA with strobes high and dq_oe=0; no SRAM write occurs until wr_valid rises; data correct afterwards.
4. Write 2 words at 0x7FFFE. Required: slices land at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
5. Reset asserted during the STROBE of word 1 of a 4-word read. Required: the next cycle shows reset values, no done, no rd_valid; a subsequent command completes normally.
6. Variant WORD_W=16, WAIT_CYCLES=1, read 2 words. Required: one slice per word, oe_n low 2 cycles per slice (SETUP plus one STROBE), rd_valid pulses 3 cycles apart.
